// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte per request onto the sensor TX line using
// asynchronous UART framing (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_send_en    level request; a frame starts on any edge where it is high and the block is idle
//   i_data_byte  byte to send, sampled only on the accept edge
//   o_tx         serial line, idles high, always driven from a register
//   o_tx_busy    high while a frame is in progress
//   o_tx_done    one-cycle pulse in the final cycle of the last stop bit
`timescale 1ns/1ps
module uart_byte_tx #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD      = 57600,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_send_en,
   input  logic [7:0] i_data_byte,
   output logic       o_tx,
   output logic       o_tx_busy,
   output logic       o_tx_done
);

   localparam int unsigned BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);
   // Index of the last stop bit in r_stop.
   localparam logic LAST_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_bit, w_bit_nxt;
   logic             r_stop, w_stop_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_par, w_par_nxt;
   logic             r_tx, w_tx_nxt;
   logic             r_busy, w_busy_nxt;

   logic             w_baud_end;
   logic [2:0]       w_bit_inc;

   assign w_baud_end = (r_cnt == CNT_MAX);
   assign w_bit_inc  = r_bit + 3'd1;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_stop  <= 1'b0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_stop  <= w_stop_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next-state logic; w_tx_nxt is the line level for the bit that starts next cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_stop_nxt  = r_stop;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_tx_nxt    = r_tx;
      w_busy_nxt  = r_busy;

      if (r_state != StIdle) begin
         w_cnt_nxt = w_baud_end ? '0 : r_cnt + CNT_W'(1);
      end

      unique case (r_state)
         StIdle: begin
            w_cnt_nxt = '0;
            w_tx_nxt  = 1'b1;
            if (i_send_en) begin
               w_state_nxt = StStart;
               w_shift_nxt = i_data_byte;
               // Odd parity inverts the XOR reduction so the nine-bit total is odd.
               w_par_nxt   = (PARITY == 1) ? ~(^i_data_byte) : ^i_data_byte;
               w_tx_nxt    = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         StStart: begin
            if (w_baud_end) begin
               w_state_nxt = StData;
               w_bit_nxt   = 3'd0;
               w_tx_nxt    = r_shift[0];
            end
         end
         StData: begin
            if (w_baud_end) begin
               if (r_bit == 3'd7) begin
                  if (PARITY != 0) begin
                     w_state_nxt = StParity;
                     w_tx_nxt    = r_par;
                  end else begin
                     w_state_nxt = StStop;
                     w_stop_nxt  = 1'b0;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_bit_nxt = w_bit_inc;
                  w_tx_nxt  = r_shift[w_bit_inc];
               end
            end
         end
         StParity: begin
            if (w_baud_end) begin
               w_state_nxt = StStop;
               w_stop_nxt  = 1'b0;
               w_tx_nxt    = 1'b1;
            end
         end
         StStop: begin
            if (w_baud_end) begin
               if (r_stop == LAST_STOP) begin
                  w_state_nxt = StIdle;
                  w_busy_nxt  = 1'b0;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_stop_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_busy_nxt  = 1'b0;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   // Outputs
   always_comb begin
      o_tx_busy = r_busy;
      o_tx_done = (r_state == StStop) && w_baud_end && (r_stop == LAST_STOP);
   end

   assign o_tx = r_tx;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: five instances with different framing parameters share clock,
// reset and data; one is selected at a time. Expected line waveforms are built from the
// frame layout (start, data LSB first, parity from a ones count, stop bits).
`timescale 1ns/1ps
module tb_uart_byte_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       send_en = 1'b0;
   logic [7:0] data_byte = 8'h00;
   logic [2:0] sel = 3'd0;
   logic [4:0] en, tx, busy, done;
   logic       w_tx, w_busy, w_done;

   int tests = 0;
   int fails = 0;
   int total_done = 0;

   always #5 clk = ~clk;

   assign en     = send_en ? (5'b00001 << sel) : 5'b00000;
   assign w_tx   = tx[sel];
   assign w_busy = busy[sel];
   assign w_done = done[sel];

   // 0: 8N1 div 10, 1: even div 10, 2: odd div 10, 3: even + 2 stop div 10, 4: defaults
   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .i_send_en(en[0]), .i_data_byte(data_byte),
      .o_tx(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u_e1 (
      .clk(clk), .rst_n(rst_n), .i_send_en(en[1]), .i_data_byte(data_byte),
      .o_tx(tx[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_o1 (
      .clk(clk), .rst_n(rst_n), .i_send_en(en[2]), .i_data_byte(data_byte),
      .o_tx(tx[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));
   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(2)) u_e2 (
      .clk(clk), .rst_n(rst_n), .i_send_en(en[3]), .i_data_byte(data_byte),
      .o_tx(tx[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]));
   uart_byte_tx u_def (
      .clk(clk), .rst_n(rst_n), .i_send_en(en[4]), .i_data_byte(data_byte),
      .o_tx(tx[4]), .o_tx_busy(busy[4]), .o_tx_done(done[4]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a frame from the current negedge (DUT idle) and checks it cycle by cycle,
   // returning at the negedge of the single idle cycle after tx_done.
   task automatic send_frame(input string tag, input logic [7:0] b, input int div,
                             input int par, input int stops, input bit keep_en,
                             input int chg_at, input logic [7:0] chg_byte);
      logic exp_bits[$];
      int   nbits, n, ones;
      int   tx_err, first_bad, busy_err, done_cnt, done_pos, bitn;
      logic [7:0] rx;
      logic rx_par, exp_par;

      ones    = $countones(b);
      exp_par = (par == 1) ? logic'(ones % 2 == 0) : logic'(ones % 2 == 1);
      exp_bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
      if (par != 0) exp_bits.push_back(exp_par);
      for (int k = 0; k < stops; k++) exp_bits.push_back(1'b1);
      nbits = exp_bits.size();
      n     = nbits * div;

      tx_err = 0; first_bad = -1; busy_err = 0; done_cnt = 0; done_pos = -1;
      rx = 8'h00; rx_par = 1'b0;

      send_en   = 1'b1;
      data_byte = b;
      @(negedge clk);
      if (!keep_en) send_en = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (w_tx !== exp_bits[i / div]) begin
            tx_err++;
            if (first_bad < 0) first_bad = i + 1;
         end
         if (w_busy !== 1'b1) busy_err++;
         if (w_done === 1'b1) begin
            done_cnt++;
            done_pos = i + 1;
         end else if (w_done !== 1'b0) begin
            done_cnt += 100;
         end
         if (i % div == div / 2) begin
            bitn = i / div;
            if (bitn >= 1 && bitn <= 8) rx[bitn-1] = w_tx;
            if (bitn == 9 && par != 0) rx_par = w_tx;
         end
         if (i == chg_at) begin
            send_en   = 1'b0;
            data_byte = chg_byte;
         end
         @(negedge clk);
      end
      total_done += done_cnt;

      check({tag, " tx mismatching cycles"}, tx_err, 0);
      if (tx_err != 0) check({tag, " first bad tx cycle"}, first_bad, 0);
      check({tag, " busy low cycles in frame"}, busy_err, 0);
      check({tag, " tx_done pulses"}, done_cnt, 1);
      check({tag, " tx_done cycle (frame length)"}, done_pos, n);
      check({tag, " decoded byte"}, rx, b);
      if (par != 0) check({tag, " parity bit"}, rx_par, exp_par);
      check({tag, " idle tx"}, w_tx, 1'b1);
      check({tag, " idle busy"}, w_busy, 1'b0);
      check({tag, " idle done"}, w_done, 1'b0);
   endtask

   // Holds the selected instance with send_en low and verifies it stays idle.
   task automatic check_quiet(input string tag, input int cycles);
      int bad;
      bad = 0;
      for (int i = 0; i < cycles; i++) begin
         if (w_tx !== 1'b1 || w_busy !== 1'b0 || w_done !== 1'b0) bad++;
         @(negedge clk);
      end
      check({tag, " non-idle cycles"}, bad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] stream [12];
      logic [7:0] rb;
      int         done_rst;

      stream = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00,
                 8'h03, 8'h11, 8'h00, 8'h15};

      // Reset state of every instance
      repeat (3) @(negedge clk);
      check("reset tx", tx, 5'h1F);
      check("reset busy", busy, 5'h00);
      check("reset done", done, 5'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Single 8N1 byte with a one-cycle request
      sel = 3'd0;
      send_frame("single EF", 8'hEF, 10, 0, 1, 1'b0, -1, 8'h00);
      check_quiet("after single", 5);

      // Sequencer stream with send_en held high
      total_done = 0;
      for (int f = 0; f < 12; f++) begin
         send_frame($sformatf("stream %0d", f), stream[f], 10, 0, 1, 1'b1, -1, 8'h00);
      end
      send_en = 1'b0;
      check("stream done pulses", total_done, 12);
      check_quiet("after stream", 5);

      // Parity and stop-bit variants
      sel = 3'd1;
      send_frame("even 03", 8'h03, 10, 2, 1, 1'b0, -1, 8'h00);
      sel = 3'd2;
      send_frame("odd 03", 8'h03, 10, 1, 1, 1'b0, -1, 8'h00);
      sel = 3'd3;
      send_frame("even 2stop 03", 8'h03, 10, 2, 2, 1'b0, -1, 8'h00);

      // Random bytes across the divided-clock instances
      for (int s = 0; s < 4; s++) begin
         sel = 3'(s);
         for (int r = 0; r < 4; r++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame($sformatf("rand cfg%0d %02h", s, rb), rb, 10,
                       (s == 0) ? 0 : ((s == 2) ? 1 : 2), (s == 3) ? 2 : 1,
                       1'b0, -1, 8'h00);
         end
      end

      // Mid-frame send_en drop and data change during data bit 3
      sel = 3'd0;
      send_frame("midframe 11", 8'h11, 10, 0, 1, 1'b1, 44, 8'h00);
      check_quiet("after midframe", 30);

      // Reset during data bit 5 of FF
      send_en   = 1'b1;
      data_byte = 8'hFF;
      @(negedge clk);
      send_en = 1'b0;
      repeat (64) @(negedge clk);
      check("pre-reset busy", w_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset tx", w_tx, 1'b1);
      check("async reset busy", w_busy, 1'b0);
      check("async reset done", w_done, 1'b0);
      done_rst = 0;
      repeat (3) begin
         @(negedge clk);
         if (w_done !== 1'b0) done_rst++;
      end
      rst_n = 1'b1;
      check("done during reset", done_rst, 0);
      check_quiet("after reset", 5);
      send_frame("post-reset 15", 8'h15, 10, 0, 1, 1'b0, -1, 8'h00);

      // Default rate
      sel = 3'd4;
      send_frame("default 01", 8'h01, 868, 0, 1, 1'b0, -1, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Serialises one byte per request onto the TX line to the fingerprint sensor, using standard asynchronous UART framing (8N1 by default).
- Sits directly downstream of the fingerprint command sequencer. It takes the sequencer's current command byte and send-enable level.
- It returns a one-cycle completion pulse that the sequencer uses to advance to the next command byte.
- The block owns the baud-rate divider and the sensor-side TX pin.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 57600: line rate in bit/s. Bit period is BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD clock cycles (868 at the defaults).
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- send_en, input, 1: level request. While it is high and the block is idle, a new frame starts.
- data_byte, input, 8: byte to send. Sampled only on the accept edge.
- tx, output, 1: serial line. Idles high.
- tx_busy, output, 1: high while a frame is in progress.
- tx_done, output, 1: one-cycle pulse marking frame completion. Feeds the sequencer's byte-advance input.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - tx = 1, tx_busy = 0, tx_done = 0.
  - State = IDLE; baud counter, bit counter and shift register all cleared.
  - The line returns high with no partial stop bit.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If send_en = 1 at a rising edge (the accept edge), latch data_byte into the shift register and compute parity from the latched byte.
  - On the same edge: tx <= 0, tx_busy <= 1, state <= START, baud counter <= 0.
  - If send_en = 0, hold tx = 1.
- Baud counter:
  - Counts 0 .. BAUD_DIV-1 in every non-IDLE state.
  - At BAUD_DIV-1 it wraps to 0 and the state/bit advances.
  - Every bit therefore lasts exactly BAUD_DIV cycles.
- START: tx = 0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - tx = shift[bit index], LSB first.
  - After bit 7, go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY:
  - Odd parity: the 8 data bits plus the parity bit contain an odd number of 1s.
  - Even parity: the same total is even.
- STOP:
  - tx = 1 for STOP_BITS bit periods.
  - tx_done = 1 during the final clock cycle of the last stop bit only, i.e. baud counter = BAUD_DIV-1 on the last stop bit.
  - On that edge: state <= IDLE, tx_busy <= 0.
- Frame length, measured from the first tx = 0 cycle to the end of the tx_done cycle: (1 + 8 + (PARITY != 0) + STOP_BITS) × BAUD_DIV cycles.
- Back-to-back frames:
  - The upstream sequencer updates its byte index on the tx_done edge, so the new data_byte is valid in the single IDLE cycle that follows.
  - If send_en is still high, the next frame is accepted on that IDLE cycle's edge.
  - Inter-frame gap is exactly 1 clock cycle of extra idle-high (stop-bit duration + 1 cycle).
- send_en dropping mid-frame: ignored; the current frame completes and tx_done still pulses.
- data_byte changing mid-frame: ignored; the latched copy is transmitted.
- send_en high during the tx_done cycle: does not cause acceptance. Acceptance happens only from IDLE.
- tx is driven from a register; it is never combinational from the state.

Test Plan:
1. Single byte, 8N1, CLK_FREQ = 1_000_000, BAUD = 100_000 (BAUD_DIV = 10).
   - Stimulus: send_en pulsed one cycle with data_byte = 8'hEF.
   - Required: tx low for 10 cycles, then bits 1,1,1,1,0,1,1,1 for 10 cycles each, then high for 10 cycles.
   - Required: tx_done high for exactly 1 cycle at cycle 100; tx_busy high for cycles 1..100.
2. Sequencer stream:
   - Stimulus: send_en held high; data_byte advances on each tx_done through EF 01 FF FF FF FF 01 00 03 11 00 15.
   - Required: 12 frames decoded correctly by the bench receiver, 12 tx_done pulses, and an inter-frame idle of exactly 11 cycles (10-cycle stop bit + 1).
3. Parity:
   - Stimulus: PARITY = 2 with data_byte = 8'h03, then PARITY = 1 with data_byte = 8'h03.
   - Required: even parity bit = 0 and odd parity bit = 1; frame is 110 cycles; STOP_BITS = 2 gives a 120-cycle frame.
4. Mid-frame input changes:
   - Stimulus: send 8'h11; in the middle of data bit 3, drop send_en and change data_byte to 8'h00.
   - Required: 8'h11 still transmitted completely; one tx_done pulse; no second frame starts.
5. Reset mid-frame:
   - Stimulus: assert rst_n = 0 during data bit 5 of 8'hFF, release after 3 cycles, then request 8'h15.
   - Required: tx = 1 and tx_busy = 0 within the reset cycle (asynchronously); no tx_done pulse; the next frame is clean and full-length.
6. Default rate:
   - Stimulus: CLK_FREQ = 50_000_000, BAUD = 57600, data_byte = 8'h01.
   - Required: every bit lasts 868 cycles and tx_done arrives 8680 cycles after tx first goes low.
